// File: rtl/calc_pkg.sv
// Shared op codes, FSM state encoding and default width for the calculator sequencer.
package calc_pkg;

   localparam int W_DEF = 8;

   localparam logic [3:0] OP_ADD  = 4'hA;
   localparam logic [3:0] OP_SUB  = 4'hB;
   localparam logic [3:0] OP_MOD3 = 4'hC;
   localparam logic [3:0] OP_EQ   = 4'hD;
   localparam logic [3:0] OP_CLR  = 4'hE;

   // 4'h0 is not a valid op, so it doubles as "chain empty"
   localparam logic [3:0] CHAIN_NONE = 4'h0;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      A_ENT  = 3'd1,
      OP_ENT = 3'd2,
      B_ENT  = 3'd3,
      EXEC   = 3'd4,
      SHOW   = 3'd5,
      ERR    = 3'd6
   } state_t;

endpackage

// File: rtl/calc_watchdog.sv
// Cycle counter that raises expired in the TIMEOUT-th enabled cycle since the last clear.
module calc_watchdog #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;

   assign expired = enable && (cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst || clear)
         cnt <= '0;
      else if (enable && !expired)
         cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Keyboard-to-ALU sequencer: gathers A/op/B, starts the ALU, latches the result, chains ops.
module calc_seq_ctrl
   import calc_pkg::*;
#(
   parameter int W       = W_DEF,
   parameter int TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         num_valid,
   input  logic [W-1:0] num_in,
   input  logic         op_valid,
   input  logic [3:0]   op_in,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [3:0]   alu_op,
   output logic         alu_start,
   input  logic         alu_done,
   input  logic [W-1:0] alu_result,
   input  logic         alu_flag,
   output logic [W-1:0] result,
   output logic         result_flag,
   output logic         result_valid,
   output logic         busy,
   output logic         err
);

   state_t         state, state_n;
   logic [W-1:0]   a_n, b_n, result_n;
   logic [3:0]     op_n, chain, chain_n;
   logic           flag_n, rv_n, start_n;
   logic           num_ev, is_clr, is_addsub, is_mod3, is_eq;
   logic           done_ok, expired;

   // An op pulse always shadows a simultaneous number entry
   assign num_ev    = num_valid && !op_valid;
   assign is_clr    = op_valid && (op_in == OP_CLR);
   assign is_addsub = op_valid && ((op_in == OP_ADD) || (op_in == OP_SUB));
   assign is_mod3   = op_valid && (op_in == OP_MOD3);
   assign is_eq     = op_valid && (op_in == OP_EQ);

   // done only counts once the start pulse has gone out
   assign done_ok = alu_done && !alu_start;

   assign busy = (state == EXEC);
   assign err  = (state == ERR);

   calc_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (state != EXEC),
      .enable  (state == EXEC),
      .expired (expired)
   );

   always_comb begin
      state_n  = state;
      a_n      = alu_a;
      b_n      = alu_b;
      op_n     = alu_op;
      chain_n  = chain;
      result_n = result;
      flag_n   = result_flag;
      rv_n     = result_valid;

      if (is_clr) begin
         state_n  = IDLE;
         a_n      = '0;
         b_n      = '0;
         op_n     = '0;
         chain_n  = CHAIN_NONE;
         result_n = '0;
         flag_n   = 1'b0;
         rv_n     = 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (num_ev) begin
                  a_n     = num_in;
                  state_n = A_ENT;
               end
            end
            A_ENT: begin
               if (num_ev) begin
                  a_n = num_in;
               end else if (is_addsub) begin
                  op_n    = op_in;
                  state_n = OP_ENT;
               end else if (is_mod3) begin
                  op_n    = OP_MOD3;
                  state_n = EXEC;
               end else if (is_eq) begin
                  result_n = alu_a;
                  flag_n   = 1'b0;
                  rv_n     = 1'b1;
                  state_n  = SHOW;
               end
            end
            OP_ENT: begin
               if (num_ev) begin
                  b_n     = num_in;
                  rv_n    = 1'b0;
                  state_n = B_ENT;
               end else if (is_addsub) begin
                  op_n = op_in;
               end
            end
            B_ENT: begin
               if (num_ev) begin
                  b_n = num_in;
               end else if (is_eq) begin
                  chain_n = CHAIN_NONE;
                  state_n = EXEC;
               end else if (is_addsub) begin
                  chain_n = op_in;
                  state_n = EXEC;
               end
            end
            EXEC: begin
               if (done_ok) begin
                  result_n = alu_result;
                  flag_n   = alu_flag;
                  rv_n     = 1'b1;
                  if (chain != CHAIN_NONE) begin
                     a_n     = alu_result;
                     op_n    = chain;
                     chain_n = CHAIN_NONE;
                     state_n = OP_ENT;
                  end else begin
                     state_n = SHOW;
                  end
               end else if (expired) begin
                  rv_n    = 1'b0;
                  state_n = ERR;
               end
            end
            SHOW: begin
               if (num_ev) begin
                  a_n     = num_in;
                  rv_n    = 1'b0;
                  state_n = A_ENT;
               end else if (is_addsub) begin
                  a_n     = result;
                  op_n    = op_in;
                  state_n = OP_ENT;
               end else if (is_mod3) begin
                  a_n     = result;
                  op_n    = OP_MOD3;
                  state_n = EXEC;
               end
            end
            ERR: begin
               rv_n = 1'b0;
               if (num_ev) begin
                  a_n     = num_in;
                  state_n = A_ENT;
               end
            end
            default: state_n = IDLE;
         endcase
      end

      start_n = (state_n == EXEC) && (state != EXEC);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         alu_a        <= '0;
         alu_b        <= '0;
         alu_op       <= '0;
         alu_start    <= 1'b0;
         chain        <= CHAIN_NONE;
         result       <= '0;
         result_flag  <= 1'b0;
         result_valid <= 1'b0;
      end else begin
         state        <= state_n;
         alu_a        <= a_n;
         alu_b        <= b_n;
         alu_op       <= op_n;
         alu_start    <= start_n;
         chain        <= chain_n;
         result       <= result_n;
         result_flag  <= flag_n;
         result_valid <= rv_n;
      end
   end

endmodule

// File: doc/calc_seq_ctrl.md
Name: calc_seq_ctrl

Overview:
- Sequencer between the keyboard front end and the calculator ALU.
- Collects operand A, operator and operand B from keyboard entry pulses, then issues a one-cycle start to the ALU and waits for its done.
- Latches the result for display and supports chained operations, where the result becomes the next A.
- Includes a watchdog that flags an ALU that never answers.

Parameters:
- W, 8: operand/result width.
- TIMEOUT, 16: max cycles from alu_start to alu_done before error.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- num_valid  in  1  one-cycle pulse; num_in is valid.
- num_in  in  W  entered number.
- op_valid  in  1  one-cycle pulse; op_in is valid.
- op_in  in  4  operator code (calc_pkg).
- alu_a  out  W  operand A to ALU.
- alu_b  out  W  operand B to ALU.
- alu_op  out  4  operator to ALU.
- alu_start  out  1  one-cycle start pulse.
- alu_done  in  1  ALU result valid (pulse or level; first high cycle counts).
- alu_result  in  W  ALU result.
- alu_flag  in  1  ALU sign/overflow flag.
- result  out  W  latched result / display value.
- result_flag  out  1  latched alu_flag.
- result_valid  out  1  result holds a completed calculation.
- busy  out  1  high in EXEC.
- err  out  1  watchdog expired.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - State goes to IDLE.
  - All outputs are 0: alu_a, alu_b, alu_op, alu_start, result, result_flag, result_valid, busy, err.
  - The pending-chain register is cleared.
- Op codes:
  - ADD=4'hA, SUB=4'hB: binary.
  - MOD3=4'hC: unary on A.
  - EQ=4'hD.
  - CLR=4'hE.
  - All other codes are ignored with no state change.
- Simultaneous num_valid and op_valid: op_valid wins; num_in is dropped.
- All captures are registered and visible the cycle after the input pulse.
- CLR in any state, including EXEC: next state IDLE, all registers cleared as at reset. A late alu_done after an aborted EXEC is ignored.
- IDLE:
  - num -> alu_a=num, go to A_ENT.
  - Other ops ignored.
- A_ENT:
  - num -> overwrite alu_a (last entry wins).
  - ADD/SUB -> alu_op=op, go to OP_ENT.
  - MOD3 -> alu_op=MOD3, go to EXEC.
  - EQ -> result=alu_a, result_flag=0, go to SHOW (ALU not used).
- OP_ENT:
  - num -> alu_b=num, go to B_ENT.
  - ADD/SUB -> replace alu_op.
  - EQ/MOD3 ignored.
- B_ENT:
  - num -> overwrite alu_b.
  - EQ -> go to EXEC, chain empty.
  - ADD/SUB -> go to EXEC, chain=op.
  - MOD3 ignored.
- EXEC:
  - alu_start=1 in the first EXEC cycle only; busy=1 throughout.
  - Entries other than CLR are ignored.
  - On alu_done (sampled from the cycle after alu_start): result=alu_result, result_flag=alu_flag.
  - Then, if chain is set: alu_a=alu_result, alu_op=chain, chain cleared, go to OP_ENT, result_valid=1.
  - Otherwise go to SHOW.
  - Watchdog counter resets on EXEC entry and increments each EXEC cycle. Reaching TIMEOUT without done -> ERR, err=1.
  - alu_done and timeout in the same cycle: done wins.
- SHOW:
  - result_valid=1.
  - num -> alu_a=num, result_valid=0, go to A_ENT.
  - ADD/SUB -> alu_a=result, alu_op=op, go to OP_ENT; result_valid stays 1 until the next num.
  - MOD3 -> alu_a=result, go to EXEC.
- ERR:
  - err=1, result_valid=0.
  - num -> err=0, alu_a=num, go to A_ENT.
  - CLR -> IDLE.
- Width rule: result is stored as delivered by the ALU (W bits). No wrap or saturation happens here.
- Minimum latency: op_valid (EQ) at cycle t -> alu_start at t+1 -> if done at t+2, result_valid at t+3.

Decomposition:
- calc_pkg holds:
  - op code localparams: OP_ADD, OP_SUB, OP_MOD3, OP_EQ, OP_CLR.
  - typedef enum state_t {IDLE, A_ENT, OP_ENT, B_ENT, EXEC, SHOW, ERR}.
  - W default.
- One sub-module, calc_watchdog: parameterised counter with clear/enable inputs and an expired output. Everything else lives in calc_seq_ctrl.

Test Plan:
- Basic add: num 10, op A, num 100, num 85, op D; ALU returns 95 two cycles after start.
  - Required: alu_a=10, alu_b=85, alu_op=A, a single alu_start pulse.
  - Then result=95, result_valid=1, busy low.
- Chain: num 20, op B, num 5, op A; ALU returns 15.
  - Required: state OP_ENT, alu_a=15, alu_op=A, result=15, result_valid=1.
  - Then num 7, op D, ALU returns 22: result=22.
- Unary and EQ passthrough:
  - num 9, op C, ALU returns 0 -> result=0.
  - num 42, op D -> result=42 with no alu_start.
- Timeout: TIMEOUT=16, alu_done held low -> err=1 exactly 16 cycles after EXEC entry. Then num 3 -> err=0, alu_a=3.
- CLR mid-EXEC: CLR one cycle after alu_start, then alu_done -> outputs all 0, state IDLE, result_valid stays 0.
- Collision and reset: num_valid and op_valid(A) in the same cycle while in A_ENT -> op taken, alu_a unchanged. rst asserted in OP_ENT -> all outputs 0 the next cycle.
